// File: rtl/tiny_dnn_pkg.sv
// tiny_dnn_pkg: shared types and constants for the tiny_dnn layer sequencer.
//   state_t        : sequencer FSM states.
//   DEF_F_NUM      : default number of accelerator filters.
//   DEF_F_SIZE     : default words per filter slot.
//   addr_t         : 13-bit accelerator / output-memory address.
package tiny_dnn_pkg;

    localparam int DEF_F_NUM  = 16;
    localparam int DEF_F_SIZE = 512;
    localparam int ADDR_W     = 13;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [3:0] {
        IDLE,
        WINIT,
        WLOAD,
        SNEXT,
        PINIT,
        EXEC,
        BIAS,
        OUT,
        DONE
    } state_t;

endpackage

// File: rtl/tiny_dnn_seq_cnt.sv
// tiny_dnn_seq_cnt: loadable terminal-count down-counter.
// Loaded with (count - 1); tc is high once the counter reaches zero, and
// the counter holds at zero instead of wrapping.
//   clk, reset : clock, synchronous active-high reset (clears to 0)
//   load       : load load_val (has priority over en)
//   load_val   : value to load
//   en         : decrement by one when non-zero
//   tc         : terminal count (counter == 0)
module tiny_dnn_seq_cnt
    import tiny_dnn_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is always updated with <= so every flop samples
    // the pre-edge values of its neighbours, independent of process order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/tiny_dnn_seq.sv
// tiny_dnn_seq: layer sequencer for the 16-filter convolution accelerator.
// Streams K weights + 1 bias per filter into the accelerator, then for each
// output pixel runs K exec cycles, one bias cycle and F read-out cycles,
// writing each read-out result to the output feature memory one cycle later.
//   clk, reset          : clock, synchronous active-high reset
//   start               : layer request, sampled only in IDLE
//   busy, done          : status (done is a one-cycle pulse at layer end)
//   id..kw              : layer geometry, counts encoded minus one
//   w_valid/w_ready/w_data : weight/bias stream
//   im_data             : input feature memory read data (same-cycle)
//   s_init, init, write, exec, outr : accelerator controls
//   acc_d / acc_x / acc_oa : accelerator data in / data out / output address
//   om_we, om_addr, om_data : output feature memory write port
module tiny_dnn_seq
    import tiny_dnn_pkg::*;
#(
    parameter int F_NUM  = DEF_F_NUM,
    parameter int F_SIZE = DEF_F_SIZE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic [3:0] id,
    input  logic [9:0] is,
    input  logic [4:0] ih,
    input  logic [4:0] iw,
    input  logic [3:0] od,
    input  logic [9:0] os,
    input  logic [4:0] oh,
    input  logic [4:0] ow,
    input  logic [2:0] kh,
    input  logic [2:0] kw,
    input  logic       w_valid,
    output logic       w_ready,
    input  real        w_data,
    input  real        im_data,
    output logic       s_init,
    output logic       init,
    output logic       write,
    output logic       exec,
    output logic       outr,
    output real        acc_d,
    input  real        acc_x,
    input  addr_t      acc_oa,
    output logic       om_we,
    output addr_t      om_addr,
    output real        om_data
);

    localparam int FW = $clog2(F_NUM + 1);   // filter / out counters
    localparam int HW = $clog2(F_SIZE + 2);  // handshake / exec counters
    localparam int PW = 10;                  // pixel counter

    state_t state, next_state;

    // Input geometry only matters to the accelerator address generator.
    logic unused_geom;
    assign unused_geom = ^{is, ih, iw, os};

    // K = (kw+1)(kh+1)(id+1) fits 10 bits given K+1 <= F_SIZE.
    // P-1 is computed modulo 1024 so P = 1024 still yields 1023.
    logic [9:0] k_val, k_m1, p_m1;
    assign k_val = ({7'd0, kw} + 10'd1) * ({7'd0, kh} + 10'd1) * ({6'd0, id} + 10'd1);
    assign k_m1  = k_val - 10'd1;
    assign p_m1  = ({5'd0, oh} + 10'd1) * ({5'd0, ow} + 10'd1) - 10'd1;

    logic hs_load, hs_en, hs_tc;
    logic flt_load, flt_en, flt_tc;
    logic ex_load, ex_en, ex_tc;
    logic pix_load, pix_en, pix_tc;
    logic out_load, out_en, out_tc;

    // Each filter takes K+1 handshakes: counter loaded with K.
    tiny_dnn_seq_cnt #(.W(HW)) u_hs_cnt (
        .clk(clk), .reset(reset), .load(hs_load), .load_val(HW'(k_val)),
        .en(hs_en), .tc(hs_tc)
    );

    tiny_dnn_seq_cnt #(.W(FW)) u_flt_cnt (
        .clk(clk), .reset(reset), .load(flt_load), .load_val(FW'(od)),
        .en(flt_en), .tc(flt_tc)
    );

    tiny_dnn_seq_cnt #(.W(HW)) u_ex_cnt (
        .clk(clk), .reset(reset), .load(ex_load), .load_val(HW'(k_m1)),
        .en(ex_en), .tc(ex_tc)
    );

    tiny_dnn_seq_cnt #(.W(PW)) u_pix_cnt (
        .clk(clk), .reset(reset), .load(pix_load), .load_val(p_m1),
        .en(pix_en), .tc(pix_tc)
    );

    tiny_dnn_seq_cnt #(.W(FW)) u_out_cnt (
        .clk(clk), .reset(reset), .load(out_load), .load_val(FW'(od)),
        .en(out_en), .tc(out_tc)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        hs_load    = 1'b0;
        hs_en      = 1'b0;
        flt_load   = 1'b0;
        flt_en     = 1'b0;
        ex_load    = 1'b0;
        ex_en      = 1'b0;
        pix_load   = 1'b0;
        pix_en     = 1'b0;
        out_load   = 1'b0;
        out_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) next_state = WINIT;
            end
            WINIT: begin
                hs_load    = 1'b1;
                flt_load   = 1'b1;
                pix_load   = 1'b1;
                next_state = WLOAD;
            end
            WLOAD: begin
                if (w_valid) begin
                    if (hs_tc) next_state = SNEXT;
                    else       hs_en      = 1'b1;
                end
            end
            SNEXT: begin
                if (flt_tc) begin
                    next_state = PINIT;
                end else begin
                    flt_en     = 1'b1;
                    hs_load    = 1'b1;
                    next_state = WLOAD;
                end
            end
            PINIT: begin
                ex_load    = 1'b1;
                next_state = EXEC;
            end
            EXEC: begin
                if (ex_tc) next_state = BIAS;
                else       ex_en      = 1'b1;
            end
            BIAS: begin
                out_load   = 1'b1;
                next_state = OUT;
            end
            OUT: begin
                if (out_tc) begin
                    if (pix_tc) begin
                        next_state = DONE;
                    end else begin
                        pix_en     = 1'b1;
                        next_state = PINIT;
                    end
                end else begin
                    out_en = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Moore outputs are decoded from next_state and registered, so they are
    // aligned with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            w_ready <= 1'b0;
            s_init  <= 1'b0;
            init    <= 1'b0;
            exec    <= 1'b0;
            outr    <= 1'b0;
            om_we   <= 1'b0;
        end else begin
            state   <= next_state;
            busy    <= (next_state != IDLE);
            done    <= (next_state == DONE);
            w_ready <= (next_state == WLOAD);
            s_init  <= (next_state == SNEXT);
            init    <= (next_state == WINIT) || (next_state == PINIT);
            exec    <= (next_state == EXEC);
            outr    <= (next_state == OUT);
            // The accelerator presents x/oa for a read-out one cycle later.
            om_we   <= outr;
        end
    end

    assign write = w_ready & w_valid;

    always_comb begin
        acc_d = 0.0;
        if (state == WLOAD)     acc_d = w_data;
        else if (state == EXEC) acc_d = im_data;
    end

    assign om_addr = om_we ? acc_oa : '0;
    assign om_data = om_we ? acc_x  : 0.0;

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// tb_tiny_dnn_seq: directed bench for tiny_dnn_seq with a behavioural
// accelerator model (weight store, accumulators, read-out address p + f*os).
module tb_tiny_dnn_seq;
    import tiny_dnn_pkg::*;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       busy, done;
    logic [3:0] g_id, g_od;
    logic [9:0] g_is, g_os;
    logic [4:0] g_ih, g_iw, g_oh, g_ow;
    logic [2:0] g_kh, g_kw;
    logic       w_valid, w_ready;
    real        w_data, im_data;
    logic       s_init, init, write, exec, outr;
    real        acc_d, acc_x;
    addr_t      acc_oa;
    logic       om_we;
    addr_t      om_addr;
    real        om_data;

    tiny_dnn_seq dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .id(g_id), .is(g_is), .ih(g_ih), .iw(g_iw),
        .od(g_od), .os(g_os), .oh(g_oh), .ow(g_ow), .kh(g_kh), .kw(g_kw),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .im_data(im_data),
        .s_init(s_init), .init(init), .write(write), .exec(exec), .outr(outr),
        .acc_d(acc_d), .acc_x(acc_x), .acc_oa(acc_oa),
        .om_we(om_we), .om_addr(om_addr), .om_data(om_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input real got, input real exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %g, expected %g", tag, got, exp);
        end
    endtask

    // ---------------- accelerator model ----------------
    real   wmem [0:15][0:7];
    real   macc [0:15];
    int    mf, mw, me, mo, mpix;
    bit    exec_d, loading;
    real   im_base = 0.0;

    always_comb im_data = im_base + real'(mpix);

    always @(posedge clk) begin
        if (reset) begin
            loading = 1'b1;
            mf = 0; mw = 0; me = 0; mo = 0; mpix = 0;
            exec_d = 1'b0;
            acc_x  <= 0.0;
            acc_oa <= '0;
        end else begin
            if (init) begin
                if (loading) begin mf = 0; mw = 0; end
                for (int f = 0; f < 16; f++) macc[f] = 0.0;
                me = 0; mo = 0;
            end
            if (write) begin
                if (mf < 16 && mw < 8) wmem[mf][mw] = acc_d;
                mw++;
            end
            if (s_init) begin
                if (mf == int'(g_od)) begin loading = 1'b0; mpix = 0; end
                else begin mf++; mw = 0; end
            end
            if (exec) begin
                for (int f = 0; f <= int'(g_od); f++)
                    if (me < 8) macc[f] += wmem[f][me] * acc_d;
                me++;
            end
            if (exec_d && !exec) begin
                for (int f = 0; f <= int'(g_od); f++)
                    if (me < 8) macc[f] += wmem[f][me];
            end
            exec_d = exec;
            if (outr) begin
                acc_x  <= (mo < 16) ? macc[mo] : 0.0;
                acc_oa <= addr_t'(mpix + mo * int'(g_os));
                if (mo >= int'(g_od)) begin mo = 0; mpix++; end
                else mo++;
            end
            if (done) loading = 1'b1;
        end
    end

    // ---------------- stimulus / logging ----------------
    real wq[$];
    int  om_addr_log[$];
    real om_data_log[$];
    int  om_rel_log[$];
    int  sinit_log[$];
    int  n_write, n_exec, n_done, done_rel, bad_write, sinit_bad;
    int  exp_addr[$];
    real exp_data[$];

    task automatic set_geom(input int kw, input int kh, input int id,
                            input int od, input int ow, input int oh, input int os);
        g_kw = 3'(kw); g_kh = 3'(kh); g_id = 4'(id); g_od = 4'(od);
        g_ow = 5'(ow); g_oh = 5'(oh); g_os = 10'(os);
        g_is = '0; g_ih = '0; g_iw = '0;
    endtask

    // Runs one layer; cycle 0 is the start cycle. restart_at/reset_at < 0
    // disables that disturbance. Ends after done, or the cycle after reset.
    task automatic run_layer(input int restart_at, input int reset_at, input bit toggle);
        int  rel = 0;
        bit  vbit = 1'b1;
        bit  finished = 1'b0;
        bit  hs;
        int  last_write_rel = -10;
        om_addr_log.delete(); om_data_log.delete(); om_rel_log.delete(); sinit_log.delete();
        n_write = 0; n_exec = 0; n_done = 0; done_rel = -1; bad_write = 0; sinit_bad = 0;
        @(posedge clk); #2;
        while (!finished && rel < 2000) begin
            start   = (rel == 0) || (rel == restart_at);
            reset   = (rel == reset_at);
            w_valid = toggle ? vbit : 1'b1;
            w_data  = (wq.size() > 0) ? wq[0] : 0.0;
            @(negedge clk);
            hs = w_valid && w_ready;
            if (write) begin
                n_write++;
                last_write_rel = rel;
                if (!w_valid) bad_write++;
            end
            if (s_init) begin
                sinit_log.push_back(n_write);
                if (last_write_rel != rel - 1) sinit_bad++;
            end
            if (exec) n_exec++;
            if (om_we) begin
                om_addr_log.push_back(int'(om_addr));
                om_data_log.push_back(om_data);
                om_rel_log.push_back(rel);
            end
            if (done) begin
                n_done++;
                done_rel = rel;
                finished = 1'b1;
            end
            if (reset_at >= 0 && rel == reset_at + 1) begin
                check("rst_busy", real'(busy), 0.0);
                check("rst_outr", real'(outr), 0.0);
                check("rst_om_we", real'(om_we), 0.0);
                finished = 1'b1;
            end
            @(posedge clk);
            if (hs && wq.size() > 0) void'(wq.pop_front());
            vbit = !vbit;
            #2;
            rel++;
        end
        start = 1'b0; reset = 1'b0; w_valid = 1'b0; w_data = 0.0;
        check("layer_terminated", real'(finished), 1.0);
    endtask

    task automatic check_om(input string tag);
        check({tag, "_om_count"}, real'(om_addr_log.size()), real'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < om_addr_log.size()) begin
                check($sformatf("%s_addr%0d", tag, i), real'(om_addr_log[i]), real'(exp_addr[i]));
                check($sformatf("%s_data%0d", tag, i), om_data_log[i], exp_data[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; w_valid = 1'b0; w_data = 0.0;
        set_geom(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", real'({busy, done, w_ready, write, s_init, init, exec, outr, om_we}), 0.0);
        check("reset_acc_d", acc_d, 0.0);

        // w_valid while IDLE is ignored.
        @(posedge clk); #2;
        reset = 1'b0; w_valid = 1'b1; w_data = 5.0;
        @(negedge clk);
        check("idle_w_ready", real'(w_ready), 0.0);
        check("idle_write", real'(write), 0.0);
        check("idle_acc_d", acc_d, 0.0);
        check("idle_busy", real'(busy), 0.0);
        w_valid = 1'b0;

        // Minimum layer: 2.0 * 3.0 + 0.5.
        set_geom(0, 0, 0, 0, 0, 0, 0);
        im_base = 3.0;
        wq = '{2.0, 0.5};
        run_layer(-1, -1, 1'b0);
        exp_addr = '{0}; exp_data = '{6.5};
        check_om("min");
        if (om_rel_log.size() > 0) check("min_om_rel", real'(om_rel_log[0]), 9.0);
        check("min_done_rel", real'(done_rel), 9.0);
        check("min_done_cnt", real'(n_done), 1.0);
        check("min_writes", real'(n_write), 2.0);
        check("min_exec", real'(n_exec), 1.0);

        // Toggling w_valid, K=1, F=2, os=2.
        set_geom(0, 0, 0, 1, 0, 0, 2);
        im_base = 3.0;
        wq = '{2.0, 0.5, 1.0, 1.0};
        run_layer(-1, -1, 1'b1);
        check("tog_writes", real'(n_write), 4.0);
        check("tog_bad_write", real'(bad_write), 0.0);
        check("tog_sinit_cnt", real'(sinit_log.size()), 2.0);
        if (sinit_log.size() == 2) begin
            check("tog_sinit0", real'(sinit_log[0]), 2.0);
            check("tog_sinit1", real'(sinit_log[1]), 4.0);
        end
        check("tog_sinit_after_write", real'(sinit_bad), 0.0);
        exp_addr = '{0, 2}; exp_data = '{6.5, 4.0};
        check_om("tog");
        check("tog_done_cnt", real'(n_done), 1.0);

        // K=4, F=2, P=4, os=4; im_data = 1 + pixel.
        set_geom(1, 1, 0, 1, 1, 1, 4);
        im_base = 1.0;
        wq = '{1.0, 1.0, 1.0, 1.0, 0.25, 0.5, 0.5, 0.5, 0.5, 1.0};
        run_layer(-1, -1, 1'b0);
        exp_addr = '{0, 4, 1, 5, 2, 6, 3, 7};
        exp_data = '{4.25, 3.0, 8.25, 5.0, 12.25, 7.0, 16.25, 9.0};
        check_om("geo");
        check("geo_exec", real'(n_exec), 16.0);
        check("geo_writes", real'(n_write), 10.0);
        check("geo_done_rel", real'(done_rel), 46.0);
        check("geo_done_cnt", real'(n_done), 1.0);

        // Same layer with start re-asserted mid-EXEC.
        wq = '{1.0, 1.0, 1.0, 1.0, 0.25, 0.5, 0.5, 0.5, 0.5, 1.0};
        run_layer(16, -1, 1'b0);
        check_om("restart");
        check("restart_exec", real'(n_exec), 16.0);
        check("restart_done_rel", real'(done_rel), 46.0);
        check("restart_done_cnt", real'(n_done), 1.0);

        // Reset during OUT of a minimum layer, then a clean rerun.
        set_geom(0, 0, 0, 0, 0, 0, 0);
        im_base = 3.0;
        wq = '{2.0, 0.5};
        run_layer(-1, 8, 1'b0);
        check("rst_om_count", real'(om_addr_log.size()), 0.0);
        check("rst_done_cnt", real'(n_done), 0.0);
        wq = '{2.0, 0.5};
        run_layer(-1, -1, 1'b0);
        exp_addr = '{0}; exp_data = '{6.5};
        check_om("rerun");
        check("rerun_done_rel", real'(done_rel), 9.0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tiny_dnn_seq.md
# tiny_dnn_seq

Layer sequencer that drives the control side of the 16-filter convolution accelerator for one layer. It streams filter weights and biases into the accelerator, then runs every output pixel: kernel accumulation, bias, and read-out. It muxes the accelerator data input `d` and writes read-out results to the output feature memory at the accelerator-supplied address `oa`. It sits between the host/DMA weight stream, the input/output feature memories, and the accelerator.

## Interface
- `F_NUM`, default 16: number of accelerator filters; `od+1` must not exceed it.
- `F_SIZE`, default 512: words per filter slot; `K+1` must not exceed it.
- `clk`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at layer end.
- `id, is, ih, iw, od, os, oh, ow, kh, kw`  in  4/10/5/5/4/10/5/5/3/3: layer geometry, held stable while `busy`. Counts are encoded minus one.
- `w_valid`  in  1: weight stream valid.
- `w_ready`  out  1: weight stream ready.
- `w_data`  in  real: weight or bias word.
- `im_data`  in  real: input feature memory read data for the accelerator's `ia`; combinational read, same cycle.
- `s_init, init, write, exec, outr`  out  1 each: accelerator controls.
- `acc_d`  out  real: accelerator `d`.
- `acc_x`  in  real: accelerator `x`.
- `acc_oa`  in  13: accelerator `oa`.
- `om_we`  out  1, `om_addr`  out  13, `om_data`  out  real: output feature memory write port.

## Operation
- `K = (kw+1)(kh+1)(id+1)`. Each filter holds `K` weights followed by 1 bias.
- `P = (oh+1)(ow+1)` output pixels; `F = od+1` filters.
- State outputs:
  - IDLE: all outputs low.
  - WINIT: `init=1`, 1 cycle.
  - WLOAD: `w_ready=1`; `write = w_valid`; `acc_d = w_data`. Stays until `K+1` handshakes, then goes to SNEXT.
  - SNEXT: `s_init=1`, 1 cycle. If filters loaded < F, go to WLOAD; else go to PINIT. The final `s_init` also clears the accelerator pixel/output pointers.
  - PINIT: `init=1`, 1 cycle, then EXEC.
  - EXEC: `exec=1` for exactly K consecutive cycles, never stalled; `acc_d = im_data`.
  - BIAS: 1 cycle, all controls low. The accelerator adds the bias in this cycle.
  - OUT: `outr=1` for exactly F cycles. Then go to PINIT if pixels done < P, else DONE.
  - DONE: `done=1`, 1 cycle, then IDLE.
- `acc_d` is 0.0 outside WLOAD/EXEC.
- Read-out: `om_we` is `outr` delayed 1 cycle; `om_addr = acc_oa`; `om_data = acc_x`, both combinational in the `om_we` cycle. The last result of a pixel is written during the following PINIT or DONE cycle.
- `start` while busy: ignored.
- `w_valid` outside WLOAD: ignored, no `write`.
- `reset` at any point: return to IDLE next edge; all counters cleared; no further `write`/`exec`/`om_we`.

## Timing
- Reset value of every 1-bit output and counter: 0; `acc_d`: 0.0.
- State register and control outputs are registered (Moore). Exceptions, all combinational:
  - `write` (w_valid-qualified);
  - `acc_d`;
  - `om_addr`/`om_data`.
- `start` at edge t → WINIT in cycle t+1.
- WLOAD with `w_valid` held high: K+1 cycles per filter. Each low `w_valid` cycle adds one cycle.
- Per-pixel cost: `1 + K + 1 + F` cycles.
- Minimum layer, all geometry 0 with `start` at cycle 0:
  - WINIT at cycle 1;
  - WLOAD at cycles 2–3;
  - SNEXT at cycle 4;
  - PINIT at cycle 5;
  - EXEC at cycle 6;
  - BIAS at cycle 7;
  - OUT at cycle 8;
  - DONE with `om_we` at cycle 9.
- Counter widths:
  - filter: 5b;
  - handshake: 10b (max 513);
  - exec: 10b;
  - pixel: 10b (max 1024);
  - out: 5b.
  - All compare against full counts, with no wrap.

## Structure
- Package `tiny_dnn_pkg`:
  - state enum (IDLE, WINIT, WLOAD, SNEXT, PINIT, EXEC, BIAS, OUT, DONE);
  - `F_NUM`, `F_SIZE` constants;
  - 13-bit address typedef.
- One sub-module, `tiny_dnn_seq_cnt`: a loadable terminal-count down-counter, instantiated for handshake, filter, exec, pixel and out counts.
- The FSM and the `acc_d`/`om_*` muxing stay in the top.

## Test plan
- Minimum layer against the accelerator model: weight 2.0, bias 0.5, `im_data` 3.0 → single `om_we` at cycle 9, `om_addr` 0, `om_data` 6.5; `done` at cycle 9.
- `w_valid` toggling 1,0,1 with K=1, F=2 → exactly 4 `write` pulses. `s_init` follows the 2nd and 4th pulses; no `write` during low-valid cycles.
- Geometry `kw=kh=1, id=0, od=1, ow=oh=1` (K=4, F=2, P=4) → 4 EXEC cycles per pixel and 8 `om_we` total. Addresses match accelerator `oa` (pixel p, filter f → p + f·os); `done` once.
- `start` asserted again mid-EXEC → ignored; same cycle count and outputs as an undisturbed run.
- `reset` during OUT → next cycle `busy=0`, `outr=0`, `om_we=0`. A fresh `start` then reproduces the full minimum-layer result.
- `w_valid=1` while IDLE → `w_ready=0`, `write=0`, `acc_d=0.0`.
